// File: rtl/rv32_pkg.sv
// Shared RV32M definitions: M-op funct3 codes, FSM encoding and
// the arithmetic constants used by the multiply/divide unit.
package rv32_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_SIGN = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int DIV_ITER = 32;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the M-extension unit.
// The pipeline side is the master; the execute unit is the slave.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            flush;
   logic            stall_req;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, operand_a, operand_b, flush,
      input  stall_req, busy, done, result
   );

   modport slave (
      input  start, funct3, operand_a, operand_b, flush,
      output stall_req, busy, done, result
   );

endinterface

// File: rtl/div_core_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle, DIV_ITER cycles.
// A start pulse loads the operands and restarts it even mid-division;
// iter_done is high during the cycle whose edge retires the last bit.
module div_core_restoring
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            iter_done
);

   localparam int CNT_W = $clog2(DIV_ITER);

   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  dsr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   logic [XLEN:0]    trial;
   logic [XLEN-1:0]  rem_next;
   logic             q_bit;

   // Trial subtraction of the divisor from the shifted partial remainder;
   // a borrow in the top bit means the divisor did not fit this step.
   always_comb begin
      trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
      q_bit    = ~trial[XLEN];
      rem_next = q_bit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
   end

   // Operand load on start, then shift one quotient bit in per cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         quo_q <= dividend;
         rem_q <= '0;
         dsr_q <= divisor;
         cnt_q <= CNT_W'(DIV_ITER - 1);
         run_q <= 1'b1;
      end else if (run_q) begin
         quo_q <= {quo_q[XLEN-2:0], q_bit};
         rem_q <= rem_next;
         if (cnt_q == '0) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign iter_done = run_q && (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit. Owns the control FSM, the divide special cases
// (divide by zero, signed overflow), the single-cycle multiplier and the
// sign fixup around the magnitude divider.
module muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   muldiv_unit_if.slave bus
);

   state_t          state;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] result_q;

   logic [2:0]      f3_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic            neg_quo_q;
   logic            neg_rem_q;

   logic            accept;
   logic            is_div_op;
   logic            is_signed_div;
   logic            div_by_zero;
   logic            div_overflow;
   logic            core_start;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   logic [XLEN:0]     ext_a;
   logic [XLEN:0]     ext_b;
   logic [2*XLEN-1:0] wide_a;
   logic [2*XLEN-1:0] wide_b;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   mul_result;

   logic [XLEN-1:0] core_quo;
   logic [XLEN-1:0] core_rem;
   logic            core_done;
   logic [XLEN-1:0] quo_fixed;
   logic [XLEN-1:0] rem_fixed;
   logic [XLEN-1:0] div_result;

   // Decode of the incoming op while idle: acceptance, divide special
   // cases and operand magnitudes handed straight to the divider.
   always_comb begin
      accept        = (state == ST_IDLE) && bus.start && !bus.flush;
      is_div_op     = bus.funct3[2];
      is_signed_div = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
      div_by_zero   = (bus.operand_b == '0);
      div_overflow  = is_signed_div && (bus.operand_a == INT_MIN) &&
                      (bus.operand_b == ALL_ONES);
      core_start    = accept && is_div_op && !div_by_zero && !div_overflow;
      abs_a = (is_signed_div && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
      abs_b = (is_signed_div && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;
   end

   // 33x33 signed product of the extended operands; only the low 64 bits
   // of the product are ever needed, so the multiply is done at 64 bits.
   always_comb begin
      ext_a  = {((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) && a_q[XLEN-1], a_q};
      ext_b  = {(f3_q == F3_MULH) && b_q[XLEN-1], b_q};
      wide_a = {{(XLEN-1){ext_a[XLEN]}}, ext_a};
      wide_b = {{(XLEN-1){ext_b[XLEN]}}, ext_b};
      product = wide_a * wide_b;
      mul_result = (f3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
   end

   // Sign fixup: quotient negative on sign mismatch, remainder follows the
   // dividend; funct3[1] selects remainder over quotient.
   always_comb begin
      quo_fixed  = neg_quo_q ? -core_quo : core_quo;
      rem_fixed  = neg_rem_q ? -core_rem : core_rem;
      div_result = f3_q[1] ? rem_fixed : quo_fixed;
   end

   div_core_restoring #(
      .XLEN(XLEN)
   ) u_div_core (
      .CLK       (CLK),
      .RESET     (RESET),
      .start     (core_start),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (core_quo),
      .remainder (core_rem),
      .iter_done (core_done)
   );

   // Control FSM with registered busy/done/result; flush aborts any
   // in-flight op without a completion pulse and leaves result alone.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         f3_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (bus.flush && (state != ST_IDLE)) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (accept) begin
                  f3_q      <= bus.funct3;
                  a_q       <= bus.operand_a;
                  b_q       <= bus.operand_b;
                  neg_quo_q <= is_signed_div && (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
                  neg_rem_q <= is_signed_div && bus.operand_a[XLEN-1];
                  busy_q    <= 1'b1;
                  if (!is_div_op) begin
                     state <= ST_MUL;
                  end else if (div_by_zero) begin
                     result_q <= bus.funct3[1] ? bus.operand_a : ALL_ONES;
                     done_q   <= 1'b1;
                     state    <= ST_DONE;
                  end else if (div_overflow) begin
                     result_q <= bus.funct3[1] ? '0 : INT_MIN;
                     done_q   <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     state <= ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               result_q <= mul_result;
               done_q   <= 1'b1;
               state    <= ST_DONE;
            end
            ST_DIV: begin
               if (core_done) begin
                  state <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               result_q <= div_result;
               done_q   <= 1'b1;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.stall_req = accept || (state == ST_MUL) || (state == ST_DIV) ||
                          (state == ST_SIGN);
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases,
// flush/reset aborts and randomized ops against an arithmetic model.
module tb_muldiv_unit;

   logic CLK;
   logic RESET;

   int checkCount;
   int errorCount;
   logic [31:0] lastResult;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // RISC-V M-extension results straight from the ISA definition.
   function automatic logic [31:0] refResult(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, sp;
      logic [63:0] up;
      int          ia, ib;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ia = $signed(a);
      ib = $signed(b);
      r  = '0;
      case (f3)
         3'b000: begin sp = sa * sb; r = sp[31:0]; end
         3'b001: begin sp = sa * sb; r = sp[63:32]; end
         3'b010: begin sp = sa * longint'({32'd0, b}); r = sp[63:32]; end
         3'b011: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
         3'b100: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'(ia / ib);
         end
         3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'(ia % ib);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Cycle in which done is expected, counting the start cycle as 0.
   function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issue one op, hold start while stalled (operands scrambled to show
   // they were captured), and check timing and result at completion.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b);
      logic [31:0] expRes;
      int          expLat;
      int          doneCyc;
      int          holdBad;
      expRes  = refResult(f3, a, b);
      expLat  = refLatency(f3, a, b);
      doneCyc = -1;
      holdBad = 0;
      @(negedge CLK);
      bus.start     = 1'b1;
      bus.flush     = 1'b0;
      bus.funct3    = f3;
      bus.operand_a = a;
      bus.operand_b = b;
      #1;
      checkOutput("c0_stall", {31'd0, bus.stall_req}, 32'd1);
      checkOutput("c0_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      checkOutput("c0_held_result", bus.result, lastResult);
      for (int cyc = 1; cyc <= 40 && doneCyc < 0; cyc++) begin
         @(negedge CLK);
         bus.operand_a = $urandom;
         bus.operand_b = $urandom;
         #1;
         if (bus.done) begin
            doneCyc = cyc;
            checkOutput($sformatf("result f3=%0d a=%08h b=%08h", f3, a, b), bus.result, expRes);
            checkOutput("done_stall", {31'd0, bus.stall_req}, 32'd0);
            checkOutput("done_busy", {31'd0, bus.busy}, 32'd1);
         end else if (!(bus.stall_req && bus.busy)) begin
            holdBad++;
         end
      end
      checkOutput($sformatf("latency f3=%0d", f3), doneCyc, expLat);
      checkOutput("hold_stall_busy", holdBad, 32'd0);
      lastResult = expRes;
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 100);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seenDone;
      checkCount    = 0;
      errorCount    = 0;
      lastResult    = '0;
      RESET         = 1'b1;
      bus.start     = 1'b0;
      bus.flush     = 1'b0;
      bus.funct3    = 3'd0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (3) @(negedge CLK);
      #1;
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      checkOutput("reset_stall", {31'd0, bus.stall_req}, 32'd0);
      RESET = 1'b0;

      $display("[TB] directed ops");
      applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
      applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000);
      applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
      applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
      applyStimulus(3'b101, 32'hFFFF_FFF9, 32'd2);
      applyStimulus(3'b101, 32'd5, 32'd0);
      applyStimulus(3'b111, 32'd5, 32'd0);
      applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

      $display("[TB] flush mid-divide");
      seenDone = 0;
      @(negedge CLK);
      bus.start     = 1'b1;
      bus.funct3    = 3'b100;
      bus.operand_a = 32'd100;
      bus.operand_b = 32'd7;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge CLK);
         #1;
         if (bus.done) seenDone++;
         if (cyc == 10) bus.flush = 1'b1;
      end
      checkOutput("flush_no_done", seenDone, 32'd0);
      applyStimulus(3'b000, 32'd3, 32'd4);

      $display("[TB] flush with start while idle");
      @(negedge CLK);
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.flush  = 1'b1;
      #1;
      checkOutput("idle_flush_stall", {31'd0, bus.stall_req}, 32'd0);
      @(negedge CLK);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      checkOutput("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("idle_flush_stall2", {31'd0, bus.stall_req}, 32'd0);

      $display("[TB] reset mid-divide");
      @(negedge CLK);
      bus.start     = 1'b1;
      bus.funct3    = 3'b101;
      bus.operand_a = 32'd1000;
      bus.operand_b = 32'd3;
      for (int cyc = 1; cyc <= 5; cyc++) @(negedge CLK);
      RESET     = 1'b1;
      bus.start = 1'b0;
      @(negedge CLK);
      #1;
      checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("midreset_done", {31'd0, bus.done}, 32'd0);
      checkOutput("midreset_result", bus.result, 32'd0);
      checkOutput("midreset_stall", {31'd0, bus.stall_req}, 32'd0);
      RESET      = 1'b0;
      lastResult = '0;

      $display("[TB] randomized ops");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
      end

      @(negedge CLK);
      bus.start = 1'b0;
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
